// File: rtl/lfsr_run_ctrl_if.sv
// Word stream handshake between the run sequencer and its downstream consumer.
// The master presents word_data/word_valid, and the slave answers with word_ready.
interface lfsr_run_ctrl_if #(
  parameter int WORD_W = 32
);
  logic              word_valid;
  logic              word_ready;
  logic [WORD_W-1:0] word_data;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/lfsr_run_ctrl.sv
// Run sequencer for the LFSR capacity chain: clear, settle, then clock-enable and deserialise.
// The optional running signature is enabled by defining LFSR_RUN_SIG_EN. WORD_W must be >= 2.
module lfsr_run_ctrl #(
  parameter int          WORD_W        = 32,
  parameter int          CNT_W         = 16,
  parameter int          CLR_CYCLES    = 4,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [31:0] EXP_SIG       = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     run_len,
  output logic                 chain_clr_n,
  output logic                 chain_en,
  input  logic                 chain_q,
  lfsr_run_ctrl_if.master      word,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          sig,
  output logic                 sig_match
);
  localparam int BW   = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam int TMAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_W - 1);
  localparam logic [TW-1:0] CLR_LAST  = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] SETL_LAST = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [TW-1:0]     tcnt;
  logic [BW-1:0]     bitcnt;
  logic [CNT_W-1:0]  wcnt, len;
  logic [WORD_W-2:0] sreg;
  logic [WORD_W-1:0] data_q, shifted;
  logic              valid_q, accept, stall;

  assign accept  = valid_q && word.word_ready;
  // Freeze the chain only when the next bit would overwrite a word still held downstream.
  assign stall    = valid_q && !word.word_ready && (bitcnt == LAST_BIT);
  assign chain_en = (state == RUN) && !stall;
  assign shifted  = {sreg, chain_q};

  assign word.word_valid = valid_q;
  assign word.word_data  = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tcnt        <= '0;
      bitcnt      <= '0;
      wcnt        <= '0;
      len         <= '0;
      sreg        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      chain_clr_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (accept) valid_q <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          len    <= run_len;
          tcnt   <= '0;
          bitcnt <= '0;
          wcnt   <= '0;
          sreg   <= '0;
          busy   <= 1'b1;
          if (run_len == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= CLEAR;
          end
        end
        CLEAR: begin
          tcnt <= tcnt + 1'b1;
          if (tcnt == CLR_LAST) begin
            tcnt        <= '0;
            state       <= SETTLE;
            chain_clr_n <= 1'b1;
          end
        end
        SETTLE: begin
          tcnt <= tcnt + 1'b1;
          if (tcnt == SETL_LAST) begin
            tcnt  <= '0;
            state <= RUN;
          end
        end
        RUN: if (chain_en) begin
          sreg   <= shifted[WORD_W-2:0];
          bitcnt <= (bitcnt == LAST_BIT) ? '0 : bitcnt + 1'b1;
          if (bitcnt == LAST_BIT) begin
            data_q  <= shifted;
            valid_q <= 1'b1;
            wcnt    <= wcnt + 1'b1;
            if (CNT_W'(wcnt + 1'b1) == len) state <= DRAIN;
          end
        end
        DRAIN: if (accept) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state       <= IDLE;
          done        <= 1'b0;
          busy        <= 1'b0;
          chain_clr_n <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // Abort wins over completion: the held word is dropped and done never fires.
      if (abort && state != IDLE) begin
        state       <= IDLE;
        valid_q     <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b0;
        chain_clr_n <= 1'b0;
      end
    end
  end

`ifdef LFSR_RUN_SIG_EN
  logic [31:0] w32;
  assign w32 = 32'(data_q);

  always_ff @(posedge clk) begin
    if (reset)                         sig <= '0;
    else if (state == IDLE && start && !abort) sig <= '0;
    else if (accept && !abort)         sig <= {sig[30:0], sig[31]} ^ w32;
  end

  assign sig_match = (sig == EXP_SIG);
`else
  assign sig       = '0;
  // Constant zero; folding EXP_SIG in keeps the parameter referenced.
  assign sig_match = 1'b0 & (^EXP_SIG);
`endif
endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Randomised bench for lfsr_run_ctrl: a modelled serial chain source plus a word-level scoreboard.
module tb_lfsr_run_ctrl;
  localparam int W = 32, CW = 16, CLR = 4, SET = 2;

  logic          clk = 1'b0;
  logic          reset, start, abort, chain_q;
  logic          chain_clr_n, chain_en, busy, done, sig_match;
  logic [CW-1:0] run_len;
  logic [31:0]   sig;

  lfsr_run_ctrl_if #(.WORD_W(W)) word ();

  lfsr_run_ctrl #(
    .WORD_W(W), .CNT_W(CW), .CLR_CYCLES(CLR), .SETTLE_CYCLES(SET), .EXP_SIG(32'hFFFFFFFF)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .run_len(run_len),
    .chain_clr_n(chain_clr_n), .chain_en(chain_en), .chain_q(chain_q),
    .word(word), .busy(busy), .done(done), .sig(sig), .sig_match(sig_match)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit src [8192];
  int idx, loaded, accepted;
  bit pending;
  logic [31:0] msig;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Word n is chain bits 32n..32n+31, first bit out of the chain landing in the MSB.
  function automatic logic [31:0] exp_word(input int n);
    logic [31:0] w = '0;
    for (int i = 0; i < W; i++) w = {w[30:0], src[W*n + i]};
    return w;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".en"}, chain_en, 1'b0);
    chk({tag, ".valid"}, word.word_valid, 1'b0);
    chk({tag, ".clr_n"}, chain_clr_n, 1'b0);
  endtask

  // mode: 0 random bits, 1 alternating 1,0, 2 all ones. stall_lo>0 holds ready low that many
  // cycles once the first word shows; otherwise ready is high with probability rdy_pct.
  // abort_e/start_e/rst_e pulse the input in the cycle ending at that edge after start.
  task automatic run(input int rl, input int rdy_pct, input int mode, input int stall_lo,
                     input int abort_e, input int start_e, input int rst_e, input string nm);
    int  e, stall_left, bound;
    bit  rdy, en_x, fin, stalled;
    for (int i = 0; i < 8192; i++)
      src[i] = (mode == 0) ? 1'($urandom_range(0, 1)) : (mode == 1) ? (i % 2 == 0) : 1'b1;
    idx = 0; loaded = 0; accepted = 0; pending = 0; msig = '0;
    stall_left = 0; stalled = 0; fin = (rl == 0);
    bound = 200 + rl * 240 + stall_lo;
    @(negedge clk);
    start = 1'b1; run_len = CW'(rl); chain_q = src[0]; word.word_ready = 1'b0;
    @(negedge clk);
    e = 1;
    forever begin
      if (pending && !stalled && stall_lo > 0) begin stalled = 1; stall_left = stall_lo; end
      if (stall_lo > 0) begin
        rdy = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        rdy = ($urandom_range(1, 100) <= rdy_pct);
      end
      word.word_ready = rdy;
      chain_q = src[idx];
      start   = (e == start_e);
      abort   = (e == abort_e);
      reset   = (e == rst_e);
      #1;
      en_x = (e >= 1 + CLR + SET) && (loaded < rl) && !(pending && !rdy && (idx % W == W - 1));
      chk({nm, ".busy"}, busy, 1'b1);
      if (!fin) chk({nm, ".clr_n"}, chain_clr_n, e > CLR);
      chk({nm, ".en"}, chain_en, en_x);
      chk({nm, ".valid"}, word.word_valid, pending);
      if (pending) chk({nm, ".data"}, word.word_data, exp_word(accepted));
      chk({nm, ".done"}, done, fin);
      if (fin) begin
`ifdef LFSR_RUN_SIG_EN
        chk({nm, ".sig"}, sig, msig);
        chk({nm, ".sig_match"}, sig_match, msig == 32'hFFFFFFFF);
`else
        chk({nm, ".sig"}, {sig, sig_match}, 33'h0);
`endif
        break;
      end
      if (e == abort_e || e == rst_e) begin
        @(negedge clk);
        abort = 1'b0; reset = 1'b0; start = 1'b0;
        #1;
        chk_idle({nm, ".post"});
        if (e == rst_e) chk({nm, ".post.data"}, word.word_data, '0);
        @(negedge clk);
        #1;
        chk({nm, ".post.done"}, done, 1'b0);
        return;
      end
      if (pending && rdy) begin
        msig = {msig[30:0], msig[31]} ^ exp_word(accepted);
        accepted++;
        pending = 0;
      end
      if (en_x) begin
        idx++;
        if (idx % W == 0) begin pending = 1; loaded++; end
      end
      if (accepted == rl) fin = 1;
      if (e > bound) begin
        chk({nm, ".timeout"}, 1'b0, 1'b1);
        break;
      end
      @(negedge clk);
      e++;
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; word.word_ready = 1'b0;
    #1;
    chk_idle({nm, ".end"});
    chk({nm, ".words"}, 64'(accepted), 64'(fin ? rl : -1));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; chain_q = 1'b0; run_len = '0;
    word.word_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset");
    chk("reset.data", word.word_data, '0);
    chk("reset.sig", {sig, sig_match}, 33'h0);
    reset = 1'b0;
    @(negedge clk);

    run(2, 100, 1, 0, -1, -1, -1, "alt");
    run(3, 100, 2, 40, -1, -1, -1, "stall");
    run(0, 100, 0, 0, -1, -1, -1, "len0");
    run(4, 100, 0, 0, 1 + CLR + SET + 5, -1, -1, "abort");
    run(2, 70, 0, 0, -1, -1, -1, "after_abort");
    run(3, 80, 0, 0, -1, 20, -1, "start_busy");
    run(3, 80, 0, 0, -1, -1, 30, "reset_mid");
    run(1, 100, 0, 0, -1, -1, -1, "after_reset");
    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(1, 4)), int'($urandom_range(30, 100)), 0, 0, -1, -1, -1, "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
